fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, fetch-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-003 SHALL have parameter IMEM_BYTES, default 1024, instruction-memory size in bytes.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port imem_addr  output  64  byte address to instruction ROM.
REQ-007 SHALL have port imem_instr  input  32  combinational ROM read data for imem_addr.
REQ-008 SHALL have port redirect_valid  input  1  branch/flush request from backend.
REQ-009 SHALL have port redirect_pc  input  64  new fetch target.
REQ-010 SHALL have port out_valid  output  1  head entry valid to decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts head.
REQ-012 SHALL have port out_instr  output  32  head instruction.
REQ-013 SHALL have port out_pc  output  64  head PC.
REQ-014 SHALL have port halted  output  1  PC out of ROM bounds; fetch stopped.

Function
REQ-015 SHALL hold PC in a register; imem_addr SHALL equal PC directly (no logic between).
REQ-016 SHALL define oob = (PC + 3 >= IMEM_BYTES); halted SHALL equal oob.
REQ-017 SHALL define fetch_fire = !redirect_valid && !oob && (count < DEPTH), count sampled at cycle start.
REQ-018 On fetch_fire, SHALL enqueue {PC, imem_instr} and set PC <= PC + 4 (mod 2^64).
REQ-019 When not firing and no redirect, PC SHALL hold.
REQ-020 Full queue SHALL block enqueue even if a dequeue occurs the same cycle (no full bypass).
REQ-021 Empty queue SHALL not bypass; an enqueued entry becomes visible on out_* the next cycle (1-cycle fetch latency).
REQ-022 out_valid SHALL equal (count != 0) && !redirect_valid; out_instr/out_pc SHALL show head entry.
REQ-023 Dequeue SHALL occur iff out_valid && out_ready; simultaneous enqueue+dequeue leaves count unchanged.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-025 On redirect_valid, SHALL clear queue (count, pointers to 0), set PC <= {redirect_pc[63:2], 2'b00}, no enqueue, no dequeue.
REQ-026 Redirect SHALL clear halted state if the new PC is in bounds; oob PC SHALL never enqueue.
REQ-027 Queue contents of invalid entries SHALL be don't-care; out_instr/out_pc with out_valid=0 unspecified.

Reset
REQ-028 reset SHALL take priority over redirect_valid and all handshakes.
REQ-029 On reset: PC=RESET_PC, count=0, pointers=0, out_valid=0; halted per REQ-016 from RESET_PC.
REQ-030 Reset asserted mid-stream SHALL discard all queued entries in that cycle.

Structure
REQ-031 Package fetch_pkg SHALL hold fetch_entry_t {pc[63:0], instr[31:0]}, INSTR_W=32, ADDR_W=64.
REQ-032 Queue SHALL be sub-module fetch_queue (enq/deq, flush, count), instantiated once.

Verification
REQ-033 Reset, out_ready=1, ROM word i = i -> out_pc 0,4,8,... on consecutive cycles; first out_valid 1 cycle after reset release.
REQ-034 out_ready=0 for 10 cycles -> count saturates at 4, PC holds at 16, imem_addr stable; release -> entries pc 0..12 in order, no loss/duplication.
REQ-035 redirect_valid=1, redirect_pc=0x43 with 3 queued -> out_valid=0 that cycle, next cycle PC=0x40, queue empty, next out_pc=0x40.
REQ-036 Sequential fetch to PC=1020 then 1024 -> entry 1020 delivered, halted=1 at PC=1024, no further enqueue; redirect to 0 -> halted=0.
REQ-037 Full queue with out_ready=1 -> dequeue only that cycle, enqueue next cycle; count goes 4->3->3 steady.
REQ-038 reset asserted same cycle as redirect_valid with queued entries -> PC=RESET_PC, count=0 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module : fetch_pkg
// Brief  : Shared widths and the fetch-queue entry type for the fetch unit.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module : fetch_queue
// Brief  : Circular fetch queue with flush; no full or empty bypass paths.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH   = 4,
  localparam int C_PTR_W = $clog2(DEPTH),
  localparam int C_CNT_W = C_PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               enq_i,
  input  fetch_entry_t       enq_data_i,
  input  logic               deq_i,
  output fetch_entry_t       head_o,
  output logic [C_CNT_W-1:0] count_o
);

  fetch_entry_t       mem_q [DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q;
  logic [C_PTR_W-1:0] rd_ptr_q;
  logic [C_CNT_W-1:0] count_q;
  logic               w_enq;
  logic               w_deq;

  // Guards keep the occupancy legal even if a caller misbehaves.
  assign w_enq = enq_i && (count_q != C_CNT_W'(DEPTH));
  assign w_deq = deq_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_enq) wr_ptr_q <= wr_ptr_q + C_PTR_W'(1);
      if (w_deq) rd_ptr_q <= rd_ptr_q + C_PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   count_q <= count_q + C_CNT_W'(1);
        2'b01:   count_q <= count_q - C_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; stale entries are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_enq && !reset && !flush_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module : fetch_unit
// Brief  : Sequential instruction fetch from a combinational ROM into a queue.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
  parameter int                IMEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  localparam int C_CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [C_CNT_W-1:0] w_count;
  logic               w_oob;
  logic               w_fetch_fire;
  logic               w_deq;
  fetch_entry_t       w_enq_data;
  fetch_entry_t       w_head;

  assign imem_addr = pc_q;

  // Bounds test in 65 bits so a PC near the top of the space cannot wrap in-bounds.
  assign w_oob  = ({1'b0, pc_q} + 65'd3) >= 65'(IMEM_BYTES);
  assign halted = w_oob;

  assign w_fetch_fire = !redirect_valid && !w_oob && (w_count < C_CNT_W'(DEPTH));
  assign out_valid    = (w_count != '0) && !redirect_valid;
  assign w_deq        = out_valid && out_ready;

  assign w_enq_data.pc    = pc_q;
  assign w_enq_data.instr = imem_instr;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (w_fetch_fire) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_valid),
    .enq_i      (w_fetch_fire),
    .enq_data_i (w_enq_data),
    .deq_i      (w_deq),
    .head_o     (w_head),
    .count_o    (w_count)
  );

  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

endmodule

`default_nettype wire
